// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a soc/eoc handshake.
// o_state exposes the FSM state (0 idle, 1 converting, 2 done) for checkers.
module bin_to_bcd_seq #(
   parameter int N = 7,
   parameter int D = 3
) (
   input  logic             i_clock,
   input  logic             i_reset_,
   input  logic             i_soc,
   input  logic [N-1:0]     i_x,
   output logic             o_eoc,
   output logic [4*D-1:0]   o_bcd,
   output logic [1:0]       o_state
);

   // Handshake: the producer raises i_soc only while o_eoc=1 and drops it after
   // seeing o_eoc=0; o_bcd is valid whenever o_eoc=1 and holds until the next result.

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [N-1:0]     r_sh;
   logic [4*D-1:0]   r_acc;
   logic [CW-1:0]    r_cnt;
   logic [4*D-1:0]   r_bcd;
   logic             r_eoc;

   state_t           w_state_nxt;
   logic [N-1:0]     w_sh_nxt;
   logic [4*D-1:0]   w_acc_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [4*D-1:0]   w_bcd_nxt;
   logic             w_eoc_nxt;
   logic [4*D-1:0]   w_acc_adj;
   logic [4*D-1:0]   w_acc_shl;

   // Per-digit +3 correction; nibbles are independent, no carry between them.
   always_comb begin
      w_acc_adj = r_acc;
      for (int i = 0; i < D; i++) begin
         if (r_acc[4*i +: 4] >= 4'd5) begin
            w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
         end
      end
   end

   // Upper slice of the {acc,sh} left shift; the bit leaving acc is dropped.
   assign w_acc_shl = {w_acc_adj[4*D-2:0], r_sh[N-1]};

   always_comb begin
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_bcd_nxt   = r_bcd;
      w_eoc_nxt   = r_eoc;
      case (r_state)
         S_IDLE: begin
            if (i_soc) begin
               w_sh_nxt    = i_x;
               w_acc_nxt   = '0;
               w_cnt_nxt   = CNT_INIT;
               w_eoc_nxt   = 1'b0;
               w_state_nxt = S_CONV;
            end
         end
         S_CONV: begin
            w_acc_nxt = w_acc_shl;
            w_sh_nxt  = {r_sh[N-2:0], 1'b0};
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_bcd_nxt   = w_acc_shl;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (!i_soc) begin
               w_eoc_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_eoc_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_) begin
      if (!i_reset_) begin
         r_state <= S_IDLE;
         r_sh    <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
         r_eoc   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_sh    <= w_sh_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bcd   <= w_bcd_nxt;
         r_eoc   <= w_eoc_nxt;
      end
   end

   assign o_eoc   = r_eoc;
   assign o_bcd   = r_bcd;
   assign o_state = r_state;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: reset, basic values, full sweep, handshake
// isolation and reset during a conversion.
module tb_bin_to_bcd_seq;

   localparam int N = 7;
   localparam int D = 3;
   localparam int W = 4 * D;

   logic           clk;
   logic           clk_en;
   logic           reset_n;
   logic           soc;
   logic [N-1:0]   x;
   logic           eoc;
   logic [W-1:0]   bcd;
   logic [1:0]     state;

   int             n_tests;
   int             n_fail;
   logic [W-1:0]   last_bcd;
   logic [W-1:0]   exp_q[$];

   bin_to_bcd_seq #(.N(N), .D(D)) dut (
      .i_clock (clk),
      .i_reset_(reset_n),
      .i_soc   (soc),
      .i_x     (x),
      .o_eoc   (eoc),
      .o_bcd   (bcd),
      .o_state (state)
   );

   // Clock / reset block: clock is gated so reset can be checked with it stopped.
   initial clk = 1'b0;
   always #5 if (clk_en) clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic nibbles_ok(input logic [W-1:0] b);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < D; i++) begin
         if (b[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Bounded wait for converter ready.
   task automatic wait_ready(input string tag);
      int budget;
      budget = 0;
      while (eoc !== 1'b1 && budget < 40) begin
         tick();
         budget++;
      end
      check({tag, "_ready"}, 32'(eoc), 32'd1);
   endtask

   // One conversion with exact latency checks; expected result from exp_q.
   task automatic convert(input string tag, input logic [N-1:0] xv);
      logic [W-1:0] exp;
      exp = exp_q.pop_front();
      wait_ready(tag);
      x   = xv;
      soc = 1'b1;
      tick();                                   // start edge k
      check({tag, "_eoc_start"}, 32'(eoc), 32'd0);
      soc = 1'b0;
      x   = N'($urandom_range(0, 127));
      for (int i = 1; i <= 6; i++) begin
         tick();
         check({tag, "_bcd_hold"}, 32'(bcd), 32'(last_bcd));
      end
      tick();                                   // edge k+7
      check({tag, "_bcd"}, 32'(bcd), 32'(exp));
      check({tag, "_eoc_k7"}, 32'(eoc), 32'd0);
      check({tag, "_nibbles"}, 32'(nibbles_ok(bcd)), 32'd1);
      tick();                                   // edge k+8
      check({tag, "_eoc_k8"}, 32'(eoc), 32'd1);
      last_bcd = exp;
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      clk_en   = 1'b0;
      reset_n  = 1'b1;
      soc      = 1'b0;
      x        = '0;
      last_bcd = '0;

      // Reset with the clock stopped: outputs must respond immediately.
      #3 reset_n = 1'b0;
      #1;
      check("rst_eoc", 32'(eoc), 32'd1);
      check("rst_bcd", 32'(bcd), 32'h000);
      check("rst_state", 32'(state), 32'd0);
      #2 reset_n = 1'b1;
      clk_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_eoc", 32'(eoc), 32'd1);
         check("idle_bcd", 32'(bcd), 32'h000);
      end

      // Basic values with hand-computed results.
      exp_q.push_back(12'h000); convert("x0", 7'd0);
      exp_q.push_back(12'h009); convert("x9", 7'd9);
      exp_q.push_back(12'h010); convert("x10", 7'd10);
      exp_q.push_back(12'h099); convert("x99", 7'd99);
      exp_q.push_back(12'h100); convert("x100", 7'd100);
      exp_q.push_back(12'h127); convert("x127", 7'd127);

      // Sweep of the full input range, back to back.
      for (int v = 0; v < 128; v++) exp_q.push_back(to_bcd(v));
      for (int v = 0; v < 128; v++) convert("sweep", N'(v));

      // Input isolation: x and soc wiggle during the conversion of 57.
      wait_ready("iso");
      x   = 7'd57;
      soc = 1'b1;
      tick();
      check("iso_eoc_start", 32'(eoc), 32'd0);
      for (int i = 1; i <= 6; i++) begin
         soc = i[0];
         x   = 7'd3;
         tick();
         check("iso_bcd_hold", 32'(bcd), 32'(last_bcd));
      end
      soc = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("iso_hold_eoc", 32'(eoc), 32'd0);
         check("iso_hold_bcd", 32'(bcd), 32'h057);
      end
      soc = 1'b0;
      tick();
      check("iso_release_eoc", 32'(eoc), 32'd1);
      check("iso_release_bcd", 32'(bcd), 32'h057);
      last_bcd = 12'h057;

      // Reset during a conversion discards the partial work.
      exp_q.push_back(12'h127); convert("pre_rst", 7'd127);
      x   = 7'd64;
      soc = 1'b1;
      tick();
      soc = 1'b0;
      tick();
      tick();
      #1 reset_n = 1'b0;
      #1;
      check("midrst_bcd", 32'(bcd), 32'h000);
      check("midrst_eoc", 32'(eoc), 32'd1);
      check("midrst_state", 32'(state), 32'd0);
      #1 reset_n = 1'b1;
      last_bcd = 12'h000;
      tick();
      check("post_rst_bcd", 32'(bcd), 32'h000);
      exp_q.push_back(12'h064); convert("x64", 7'd64);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter: the reverse of the combinational two-digit BCD-to-binary block. It accepts an N-bit natural number under a soc/eoc handshake and returns D packed BCD digits. It uses the iterative shift-and-add-3 (double dabble) algorithm, one bit per clock. It drives the decimal display path from the binary datapath.

## Interface
- N, 7, width of the binary input (natural number, 0..2^N-1)
- D, 3, number of output BCD digits; 10^D > 2^N-1 is required (N=7, D=3 → 0..127)
- clock  input  1  system clock, rising-edge active
- reset_  input  1  reset, asynchronous, active-low
- soc  input  1  start of conversion from producer
- x  input  N  binary operand, sampled only on the start edge
- eoc  output  1  end of conversion / converter ready
- bcd  output  4*D  result, digit i on bcd[4i+3:4i], digit D-1 most significant

## Operation
- Registers:
  - state (S_IDLE, S_CONV, S_DONE)
  - shift register sh[N-1:0]
  - working digits acc[4D-1:0]
  - bit counter cnt, ceil(log2(N+1)) bits
  - output register bcd
  - eoc flip-flop
- Reset (reset_=0, any time, asynchronous):
  - state=S_IDLE, eoc=1, bcd=0, acc=0, sh=0, cnt=0.
  - Reset asserted mid-conversion aborts the conversion; no partial result reaches bcd.
- S_IDLE (eoc=1): on an edge with soc=1:
  - sh←x, acc←0, cnt←N, eoc←0, state←S_CONV.
  - With soc=0: hold everything.
- S_CONV (eoc=0): each edge:
  - Every digit of acc with value ≥5 gets +3 (4-bit add, no carry between digits).
  - Then {acc,sh} shifts left one position; sh LSB gets 0.
  - cnt←cnt-1.
  - On the edge where cnt=1, the corrected-and-shifted acc value is also written to bcd, and state←S_DONE.
  - soc and x are ignored throughout S_CONV.
- S_DONE (eoc=0): on an edge with soc=0:
  - eoc←1, state←S_IDLE.
  - While soc=1: hold (eoc=0, bcd stable).
- bcd changes only on the final S_CONV edge and on reset. Between conversions it holds the last result, including throughout the next conversion.
- Every digit of bcd is 0..9; bcd never holds a non-BCD nibble.
- Width rules:
  - Add-3 correction is applied per nibble in 4 bits.
  - The shift is 4D+N bits wide; the bit shifted out of acc MSB is discarded. It is always 0 when 10^D > 2^N-1.

## Timing
- Start edge k: soc=1 sampled in S_IDLE. From k: eoc=0 and x captured; x may change after edge k.
- Conversion edges k+1 … k+N; bcd valid after edge k+N.
- Earliest eoc=1: after edge k+N+1, if soc=0 at that edge. Minimum start-to-eoc latency is N+1 clocks (8 for N=7).
- Producer rule: raise soc only while eoc=1; drop soc after seeing eoc=0; read bcd once eoc=1.
- If soc is held high past edge k+N, eoc stays 0 until the first edge with soc=0; the result is unaffected.
- soc=1 already present when eoc returns to 1 starts a new conversion on the next edge (back-to-back allowed).
- Outputs are registered; no combinational path from soc or x to eoc or bcd.

## Test plan
- Reset then idle:
  - Stimulus: reset_=0 mid-cycle with clock stopped.
  - Required: eoc=1 and bcd=0x000 immediately (asynchronous). After release with soc=0 for 5 cycles, both unchanged.
- Basic values (N=7, D=3), each with soc=1 then soc=0 after eoc falls:
  - x=0 → bcd=0x000.
  - x=9 → 0x009.
  - x=10 → 0x010.
  - x=99 → 0x099.
  - x=100 → 0x100.
  - x=127 → 0x127.
  - Each: eoc returns to 1 exactly 8 edges after the start edge.
- Exhaustive sweep:
  - Stimulus: x=0..127 back-to-back.
  - Required: each bcd equals the decimal digits of x; no nibble >9; previous result stable until edge k+7.
- Input/handshake isolation:
  - Stimulus: start with x=57, then change x to 3 and toggle soc during S_CONV.
  - Required: bcd=0x057.
  - Stimulus: soc held high 20 cycles.
  - Required: eoc stays 0 until the edge after soc falls; bcd=0x057 throughout.
- Reset mid-conversion:
  - Stimulus: a conversion of x=127 completes (bcd=0x127); start x=64, then assert reset_ at edge k+3.
  - Required: bcd=0x000, eoc=1, state idle.
  - Stimulus: a new start with x=64.
  - Required: bcd=0x064.
